// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported, variable-latency unified memory between the fetch
// stage (instruction reads) and the memory stage (data loads and stores).
// Data accesses have fixed priority over fetches. A starvation counter limits
// how many data grants can pass a waiting fetch, so fetch always makes
// progress. A taken jump (i_flush) drops an in-flight fetch response without
// aborting the memory access, because the memory cannot be cancelled.
//
// Parameters
//   STARVE_MAX  consecutive data grants with a fetch pending before the fetch
//               is forced through (must be >= 1)
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   rst        in   1   asynchronous active-high reset
//   i_req      in   1   fetch read request, held with i_addr until i_ready/flush
//   i_addr     in   32  fetch address
//   i_flush    in   1   jump taken: discard current/pending fetch response
//   i_ready    out  1   one-cycle pulse: i_data/i_err valid
//   i_data     out  32  fetched instruction (registered)
//   i_err      out  1   memory error on this fetch (registered)
//   d_req      in   1   data request, held with d_wr/d_addr/d_wdata until d_ready
//   d_wr       in   1   1 = store, 0 = load
//   d_addr     in   32  data address
//   d_wdata    in   32  store data
//   d_ready    out  1   one-cycle pulse: d_rdata/d_err valid (store: completion)
//   d_rdata    out  32  load data (registered)
//   d_err      out  1   memory error on this access (registered)
//   mem_en     out  1   memory access active
//   mem_wr     out  1   memory write
//   mem_addr   out  32  memory address
//   mem_wdata  out  32  memory write data
//   mem_rdata  in   32  memory read data, valid with mem_ready
//   mem_ready  in   1   memory completes the current access this cycle
//   mem_err    in   1   memory error, valid with mem_ready
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic        i_ready,
    output logic [31:0] i_data,
    output logic        i_err,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,

    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        mem_err
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [CW-1:0]   starve_cnt;
    logic            stale;
    logic            resp_is_d;
    logic            wr_latched;

    logic            starved;
    logic            grant_d;
    logic            grant_i;
    logic            capture;

    // A fetch has been passed over STARVE_MAX times in a row: it must win now,
    // even against a pending data request.
    assign starved = i_req && (starve_cnt == STARVE_LIMIT);

    // State register. Reset returns straight to IDLE, which also drops mem_en
    // asynchronously since mem_en is decoded from the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode. RESP always lasts exactly one cycle and
    // ignores requests so the requester has a cycle to drop or change them.
    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        capture    = 1'b0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        i_ready    = 1'b0;
        d_ready    = 1'b0;

        case (state)
            IDLE: begin
                if (d_req && !starved) begin
                    grant_d    = 1'b1;
                    next_state = D_BUSY;
                end else if (i_req && !i_flush) begin
                    grant_i    = 1'b1;
                    next_state = I_BUSY;
                end
            end

            I_BUSY: begin
                mem_en = 1'b1;
                if (mem_ready) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end

            D_BUSY: begin
                mem_en = 1'b1;
                mem_wr = wr_latched;
                if (mem_ready) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end

            RESP: begin
                d_ready    = resp_is_d;
                i_ready    = !resp_is_d && !stale;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latch. The granted request is copied into the memory-side
    // registers so mem_addr/mem_wdata/mem_wr stay constant for the whole
    // access regardless of what the requester does meanwhile. resp_is_d
    // remembers which port owns the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            wr_latched <= 1'b0;
            resp_is_d  <= 1'b0;
        end else if (grant_d) begin
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            wr_latched <= d_wr;
            resp_is_d  <= 1'b1;
        end else if (grant_i) begin
            mem_addr   <= i_addr;
            mem_wdata  <= 32'd0;
            wr_latched <= 1'b0;
            resp_is_d  <= 1'b0;
        end
    end

    // Starvation counter. Counts data grants that overtook a waiting fetch,
    // saturating at the limit; any fetch grant, or an idle cycle with no fetch
    // waiting, clears it. A data grant with no fetch pending also lands in
    // the clearing branch because i_req is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_d && i_req) begin
            if (starve_cnt != STARVE_LIMIT) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if ((state == IDLE) && !i_req) begin
            starve_cnt <= '0;
        end
    end

    // Stale flag. A flush during a fetch cannot abort the memory access, so
    // the fetch is marked stale and its response cycle is suppressed. The
    // flag lives until the response cycle has passed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale <= 1'b0;
        end else if (state == RESP) begin
            stale <= 1'b0;
        end else if ((state == I_BUSY) && i_flush) begin
            stale <= 1'b1;
        end
    end

    // Fetch response registers. A flush arriving in the very cycle the memory
    // completes also drops the response, so i_flush is checked alongside
    // stale; a dropped fetch leaves i_data/i_err untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_data <= 32'd0;
            i_err  <= 1'b0;
        end else if (capture && (state == I_BUSY) && !stale && !i_flush) begin
            i_data <= mem_rdata;
            i_err  <= mem_err;
        end
    end

    // Data response registers. Stores capture too, so d_err reports a failed
    // store; the values hold until the next data completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rdata <= 32'd0;
            d_err   <= 1'b0;
        end else if (capture && (state == D_BUSY)) begin
            d_rdata <= mem_rdata;
            d_err   <= mem_err;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. A behavioural memory with a programmable
// number of wait cycles and an error flag answers the arbiter. Every request
// pushes its expected response (data from the bench's own memory image, error
// flag) onto a per-port queue; each ready pulse pops and compares.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        i_ready;
    logic [31:0] i_data;
    logic        i_err;
    logic        d_req;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] memArr [0:255];
    int          waitCycles = 0;
    logic        errNext = 1'b0;
    int          busyCount = 0;

    resp_t       iExp[$];
    resp_t       dExp[$];
    logic [31:0] grantLog[$];
    logic [31:0] lastIData = 32'd0;
    int          iReadyCount = 0;
    int          dReadyCount = 0;
    logic        memEnPrev = 1'b0;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_ready   (i_ready),
        .i_data    (i_data),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mem_err   (mem_err)
    );

    // Free-running clock: rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: answers on the falling edge so the arbiter samples
    // mem_ready on the following rising edge. With waitCycles = 0 the access
    // completes in its first busy cycle.
    always @(negedge clk) begin
        logic [7:0] idx;
        if (mem_en) begin
            if (busyCount == waitCycles) begin
                idx       = mem_addr[9:2];
                mem_ready = 1'b1;
                mem_err   = errNext;
                mem_rdata = memArr[idx];
                if (mem_wr) begin
                    memArr[idx] = mem_wdata;
                end
                busyCount = 0;
            end else begin
                mem_ready = 1'b0;
                mem_err   = 1'b0;
                mem_rdata = 32'd0;
                busyCount = busyCount + 1;
            end
        end else begin
            mem_ready = 1'b0;
            mem_err   = 1'b0;
            mem_rdata = 32'd0;
            busyCount = 0;
        end
    end

    // Observer: counts ready pulses and logs the address of every new grant.
    always @(negedge clk) begin
        if (i_ready) iReadyCount = iReadyCount + 1;
        if (d_ready) dReadyCount = dReadyCount + 1;
        if (mem_en && !memEnPrev) grantLog.push_back(mem_addr);
        memEnPrev = mem_en;
    end

    // Hard stop in case something hangs outside a bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            errors = errors + 1;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input bit isD, input logic [31:0] addr);
        resp_t r;
        logic [7:0] idx;
        idx    = addr[9:2];
        r.data = memArr[idx];
        r.err  = errNext;
        if (isD) dExp.push_back(r);
        else     iExp.push_back(r);
    endtask

    task automatic applyStimulus(input bit isD, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (isD) begin
            d_req   = 1'b1;
            d_wr    = wr;
            d_addr  = addr;
            d_wdata = wdata;
        end else begin
            i_req  = 1'b1;
            i_addr = addr;
        end
        pushExpect(isD, addr);
    endtask

    task automatic checkResponse(input bit isD);
        resp_t r;
        if (isD) begin
            if (dExp.size() == 0) begin
                checkOutput("d_unexpected_ready", {31'd0, d_ready}, 32'd0);
            end else begin
                r = dExp.pop_front();
                checkOutput("d_rdata", d_rdata, r.data);
                checkOutput("d_err", {31'd0, d_err}, {31'd0, r.err});
            end
        end else begin
            if (iExp.size() == 0) begin
                checkOutput("i_unexpected_ready", {31'd0, i_ready}, 32'd0);
            end else begin
                r = iExp.pop_front();
                checkOutput("i_data", i_data, r.data);
                checkOutput("i_err", {31'd0, i_err}, {31'd0, r.err});
                lastIData = r.data;
            end
        end
    endtask

    task automatic runResponses(input int n, input int budget, input bit holdReqs);
        int got;
        got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (i_ready) begin
                checkResponse(1'b0);
                got = got + 1;
                if (!holdReqs) i_req = 1'b0;
            end
            if (d_ready) begin
                checkResponse(1'b1);
                got = got + 1;
                if (!holdReqs) d_req = 1'b0;
            end
        end
        checkOutput("response_count", got, n);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_i_ready"},   {31'd0, i_ready}, 32'd0);
        checkOutput({tag, "_i_data"},    i_data,           32'd0);
        checkOutput({tag, "_i_err"},     {31'd0, i_err},   32'd0);
        checkOutput({tag, "_d_ready"},   {31'd0, d_ready}, 32'd0);
        checkOutput({tag, "_d_rdata"},   d_rdata,          32'd0);
        checkOutput({tag, "_d_err"},     {31'd0, d_err},   32'd0);
        checkOutput({tag, "_mem_en"},    {31'd0, mem_en},  32'd0);
        checkOutput({tag, "_mem_wr"},    {31'd0, mem_wr},  32'd0);
        checkOutput({tag, "_mem_addr"},  mem_addr,         32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata,        32'd0);
    endtask

    // Directed sequence: reset, single fetch latency, starvation ordering,
    // store with wait states, flush cases, reset mid-access, error reporting.
    initial begin
        logic [31:0] expGrant [0:9];
        int          snapI;
        int          snapD;

        for (int i = 0; i < 256; i++) begin
            memArr[i] = 32'hC000_0000 | (i * 32'h0001_0203);
        end
        memArr[64] = 32'h0050_0093;

        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'd0; i_flush = 1'b0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        mem_ready = 1'b0; mem_err = 1'b0; mem_rdata = 32'd0;

        $display("[TB] reset state");
        @(negedge clk);
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] single fetch, zero-wait memory");
        waitCycles = 0;
        applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'd0);
        @(negedge clk);
        checkOutput("t1_mem_en_busy", {31'd0, mem_en}, 32'd1);
        checkOutput("t1_mem_addr", mem_addr, 32'h0000_0100);
        checkOutput("t1_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("t1_no_early_ready", {31'd0, i_ready}, 32'd0);
        @(negedge clk);
        checkOutput("t1_i_ready", {31'd0, i_ready}, 32'd1);
        checkOutput("t1_mem_en_resp", {31'd0, mem_en}, 32'd0);
        checkResponse(1'b0);
        checkOutput("t1_i_data_value", i_data, 32'h0050_0093);
        i_req = 1'b0;
        @(negedge clk);
        checkOutput("t1_ready_one_cycle", {31'd0, i_ready}, 32'd0);

        $display("[TB] starvation ordering with both requests held");
        grantLog.delete();
        i_req = 1'b1; i_addr = 32'h0000_0140;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_0180; d_wdata = 32'd0;
        for (int k = 0; k < 8; k++) pushExpect(1'b1, 32'h0000_0180);
        for (int k = 0; k < 2; k++) pushExpect(1'b0, 32'h0000_0140);
        runResponses(10, 200, 1'b1);
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 10; k++) expGrant[k] = 32'h0000_0180;
        expGrant[4] = 32'h0000_0140;
        expGrant[9] = 32'h0000_0140;
        checkOutput("t2_grant_count", grantLog.size(), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < grantLog.size()) begin
                checkOutput($sformatf("t2_grant%0d", k), grantLog[k], expGrant[k]);
            end
        end
        @(negedge clk);

        $display("[TB] store with three wait cycles");
        snapI = iReadyCount;
        waitCycles = 3;
        applyStimulus(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t3_mem_en%0d", k), {31'd0, mem_en}, 32'd1);
            checkOutput($sformatf("t3_mem_wr%0d", k), {31'd0, mem_wr}, 32'd1);
            checkOutput($sformatf("t3_mem_addr%0d", k), mem_addr, 32'h0000_0200);
            checkOutput($sformatf("t3_mem_wdata%0d", k), mem_wdata, 32'hDEAD_BEEF);
            checkOutput($sformatf("t3_no_ready%0d", k), {31'd0, d_ready}, 32'd0);
        end
        @(negedge clk);
        checkOutput("t3_d_ready", {31'd0, d_ready}, 32'd1);
        checkOutput("t3_mem_en_resp", {31'd0, mem_en}, 32'd0);
        checkOutput("t3_mem_wr_resp", {31'd0, mem_wr}, 32'd0);
        checkResponse(1'b1);
        d_req = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t3_no_i_ready", iReadyCount, snapI);
        waitCycles = 0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'd0);
        runResponses(1, 20, 1'b0);
        checkOutput("t3_readback", d_rdata, 32'hDEAD_BEEF);

        $display("[TB] flush during fetch");
        @(negedge clk);
        snapI = iReadyCount;
        waitCycles = 2;
        i_req = 1'b1; i_addr = 32'h0000_0300;
        @(negedge clk);
        checkOutput("t4_busy", {31'd0, mem_en}, 32'd1);
        i_flush = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        i_flush = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("t4_no_i_ready", iReadyCount, snapI);
        checkOutput("t4_i_data_held", i_data, lastIData);
        checkOutput("t4_idle", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0000_0304, 32'd0);
        runResponses(1, 20, 1'b0);

        $display("[TB] flush in the completion cycle");
        waitCycles = 0;
        @(negedge clk);
        snapI = iReadyCount;
        i_req = 1'b1; i_addr = 32'h0000_0308;
        @(negedge clk);
        checkOutput("t4b_busy", {31'd0, mem_en}, 32'd1);
        i_flush = 1'b1;
        i_req = 1'b0;
        @(negedge clk);
        i_flush = 1'b0;
        checkOutput("t4b_no_ready", {31'd0, i_ready}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("t4b_ready_count", iReadyCount, snapI);
        checkOutput("t4b_i_data_held", i_data, lastIData);

        $display("[TB] flush in idle blocks the grant for one cycle");
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_030C; i_flush = 1'b1;
        @(negedge clk);
        checkOutput("t4c_blocked", {31'd0, mem_en}, 32'd0);
        i_flush = 1'b0;
        pushExpect(1'b0, 32'h0000_030C);
        runResponses(1, 20, 1'b0);

        $display("[TB] reset during a data access");
        @(negedge clk);
        snapD = dReadyCount;
        waitCycles = 5;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_01A0; d_wdata = 32'd0;
        @(negedge clk);
        checkOutput("t5_busy", {31'd0, mem_en}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("t5_rst");
        @(negedge clk);
        rst = 1'b0;
        waitCycles = 0;
        pushExpect(1'b1, 32'h0000_01A0);
        @(negedge clk);
        checkOutput("t5_regrant", {31'd0, mem_en}, 32'd1);
        checkOutput("t5_regrant_addr", mem_addr, 32'h0000_01A0);
        #1;
        checkOutput("t5_no_ready_from_aborted", dReadyCount, snapD);
        runResponses(1, 20, 1'b0);

        $display("[TB] memory error reporting");
        @(negedge clk);
        errNext = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0000_01C0, 32'd0);
        runResponses(1, 20, 1'b0);
        errNext = 1'b0;
        @(negedge clk);
        checkOutput("t6_d_err_held", {31'd0, d_err}, 32'd1);
        checkOutput("t6_d_ready_low", {31'd0, d_ready}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_01C4, 32'd0);
        runResponses(1, 20, 1'b0);
        @(negedge clk);
        errNext = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0000_0110, 32'd0);
        runResponses(1, 20, 1'b0);
        errNext = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("end_i_queue_empty", iExp.size(), 32'd0);
        checkOutput("end_d_queue_empty", dExp.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
